// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam int WAIT_CYCLES_DEF = 4;
endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr: loadable down-counter flagging the final wait-state cycle
module arb_wait_ctr #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign last = cnt == CW'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port main-memory arbiter; MEM_ARB_DPRIO_EN gives port 1 fixed priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_strobe,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    state_t state, state_nx;
    logic start, last, win;
    assign start = state == IDLE && (req0 || req1);
`ifdef MEM_ARB_DPRIO_EN
    assign win = req1;
`else
    logic last_grant;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant <= PORT_D;
        else if (start) last_grant <= win;
    end
    // single requester wins outright; a tie goes to the port not served last
    assign win = (req0 && req1) ? ~last_grant : req1;
`endif
    arb_wait_ctr #(.CW(CW)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (CW'(WAIT_CYCLES)),
        .last     (last)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (start ? ACCESS : IDLE) :
                   state == ACCESS ? (last ? RESP : ACCESS) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        ack0 = state == RESP && grant == PORT_I;
        ack1 = state == RESP && grant == PORT_D;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_strobe <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant      <= PORT_I;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            mem_strobe <= start;
            if (start) begin
                grant     <= win;
                mem_rw    <= win ? rw1 : rw0;
                mem_addr  <= win ? addr1 : addr0;
                mem_wdata <= win ? wdata1 : wdata0;
            end
            if (state == ACCESS && last && !mem_rw) begin
                if (grant == PORT_D) rdata1 <= mem_rdata;
                else rdata0 <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic ack0, ack1, mem_strobe, mem_rw, busy, grant;
    logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a == 8'h40 ? 8'hA5 : 8'(a * 8'd29 + 8'd7);
    endfunction

    // memory model: stores strobed writes, returns data only in the last ACCESS cycle
    logic [7:0] mem_arr [256];
    bit wr_flag [256];
    int since = 0;
    always @(posedge clk) begin
        if (mem_strobe && mem_rw) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            wr_flag[mem_addr[7:0]] <= 1'b1;
        end
        since <= mem_strobe ? 1 : (since != 0 && since < W) ? since + 1 : 0;
    end
    always_comb begin
        mem_rdata = 8'hEE;
        if ((mem_strobe ? 0 : since) == W - 1)
            mem_rdata = wr_flag[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    end

    int errors = 0;
    int checks = 0;
    bit last_g = 1'b1;
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ack0"}, 32'(ack0), 0);
        chk({tag, "_ack1"}, 32'(ack1), 0);
        chk({tag, "_strobe"}, 32'(mem_strobe), 0);
        chk({tag, "_rw"}, 32'(mem_rw), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_rdata0"}, 32'(rdata0), 0);
        chk({tag, "_rdata1"}, 32'(rdata1), 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        check_zero("rst");
        step;
        reset = 1'b0;
        last_g = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1, input bit drop);
        bit win, w;
        logic [15:0] a;
        logic [7:0] d;
        req0 = r0; req1 = r1; rw0 = w0; rw1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        if (!r0 && !r1) begin
            step;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_strobe", 32'(mem_strobe), 0);
            return;
        end
`ifdef MEM_ARB_DPRIO_EN
        win = r1;
`else
        win = (r0 && r1) ? ~last_g : r1;
        last_g = win;
`endif
        w = win ? w1 : w0;
        a = win ? a1 : a0;
        d = win ? d1 : d0;
        step;
        chk("grant", 32'(grant), 32'(win));
        chk("busy_acc", 32'(busy), 1);
        chk("strobe_first", 32'(mem_strobe), 1);
        chk("mem_rw", 32'(mem_rw), 32'(w));
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_wdata", 32'(mem_wdata), 32'(d));
        for (int c = 2; c <= W; c++) begin
            step;
            if (drop && c == 2) begin
                if (win) req1 = 1'b0;
                else req0 = 1'b0;
            end
            chk("strobe_held_low", 32'(mem_strobe), 0);
            chk("addr_held", 32'(mem_addr), 32'(a));
            chk("rw_held", 32'(mem_rw), 32'(w));
            chk("wdata_held", 32'(mem_wdata), 32'(d));
            chk("no_early_ack", 32'(ack0 | ack1), 0);
        end
        step;
        if (w) ref_mem[a[7:0]] = d;
        else exp_rd[win] = ref_mem[a[7:0]];
        chk("ack0", 32'(ack0), 32'(!win));
        chk("ack1", 32'(ack1), 32'(win));
        chk("busy_resp", 32'(busy), 1);
        chk("rdata", 32'(win ? rdata1 : rdata0), 32'(exp_rd[win]));
        if (win) req1 = 1'b0;
        else req0 = 1'b0;
        step;
        chk("idle_after_busy", 32'(busy), 0);
        chk("idle_after_ack", 32'(ack0 | ack1), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        #1;
        do_reset;
        round(1, 0, 0, 0, 16'h0040, 16'h0000, 8'h00, 8'h00, 0);
        chk("read_a5", 32'(rdata0), 32'hA5);
        round(0, 1, 0, 1, 16'h0000, 16'h1234, 8'h00, 8'h3C, 0);
        chk("write_rdata1_kept", 32'(rdata1), 0);
        round(1, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 8'h00, 0);
        do_reset;
        for (int k = 0; k < 4; k++)
            round(1, 1, 0, 0, 16'(16'h0100 + k), 16'(16'h0200 + k), 8'h00, 8'h00, 0);
        // reset in the second ACCESS cycle
        req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0077;
        step;
        step;
        #2;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        step;
        check_zero("midrst_hold");
        reset = 1'b0;
        last_g = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        round(1, 1, 0, 1, 16'h0011, 16'h0022, 8'h00, 8'h5D, 0);
        round(1, 0, 0, 0, 16'h0040, 16'h0000, 8'h00, 8'h00, 1);
        for (int k = 0; k < 40; k++)
            round(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
